// File: rtl/periph_arb_pkg.sv
// periph_arb_pkg: shared constants and lock-state encoding for the peripheral bus arbiter.
package periph_arb_pkg;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
    localparam logic [31:0] ADDR_SW   = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI = 32'h4000_0014;
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;
endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way grant picker honouring an active lock.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    input  logic       lock_vld,
    input  logic       lock_own,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = lock_vld ? (lock_own ? {req[1], 1'b0} : {1'b0, req[0]})
            : (&req)   ? ((mode && !last) ? 2'b10 : 2'b01)
            : req;
    end
endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: zero-latency two-master arbiter for the peripheral bus
// with locked read-modify-write sequences and a bounded lock timeout.
module periph_bus_arbiter
    import periph_arb_pkg::*;
#(
    parameter int ARB_MODE = 1,
    parameter int LOCK_MAX = 16,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_rd,
    input  logic          m0_wr,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_rd,
    input  logic          m1_wr,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          p_rd,
    output logic          p_wr,
    output logic [AW-1:0] p_addr,
    output logic [DW-1:0] p_wdata,
    input  logic [DW-1:0] p_rdata,
    output logic          lock_err
);
    lock_state_e state;
    logic [1:0]  gnt;
    logic [1:0]  lock_in;
    logic [1:0]  relock_block;
    logic        last_gnt;
    logic        lock_own;
    logic [7:0]  lock_cnt;
    logic        any_gnt;
    logic        sel;
    logic        sel_rd;
    logic        sel_wr;

    assign lock_in = {m1_lock, m0_lock};

    arb_pick2 u_pick (
        .req      ({m1_req, m0_req}),
        .last     (last_gnt),
        .mode     (ARB_MODE == ARB_RR),
        .lock_vld (state == LOCKED),
        .lock_own (lock_own),
        .gnt      (gnt)
    );

    assign any_gnt = |gnt;
    assign sel     = gnt[1];
    assign sel_rd  = sel ? m1_rd : m0_rd;
    assign sel_wr  = sel ? m1_wr : m0_wr;

    assign m0_gnt   = gnt[0];
    assign m1_gnt   = gnt[1];
    assign p_wr     = any_gnt & sel_wr;
    // rd and wr together is illegal; only the write goes out
    assign p_rd     = any_gnt & sel_rd & ~sel_wr;
    assign p_addr   = any_gnt ? (sel ? m1_addr : m0_addr) : '0;
    assign p_wdata  = any_gnt ? (sel ? m1_wdata : m0_wdata) : '0;
    assign m0_rdata = gnt[0] ? p_rdata : '0;
    assign m1_rdata = gnt[1] ? p_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= UNLOCKED;
            last_gnt     <= 1'b1;
            lock_own     <= 1'b0;
            lock_cnt     <= 8'd0;
            lock_err     <= 1'b0;
            relock_block <= 2'b00;
        end else begin
            lock_err     <= 1'b0;
            relock_block <= relock_block & lock_in;
            if (any_gnt)
                last_gnt <= sel;
            if (state == UNLOCKED) begin
                if (any_gnt && lock_in[sel] && !relock_block[sel]) begin
                    state    <= LOCKED;
                    lock_own <= sel;
                    lock_cnt <= 8'd1;
                end
            end else if (!lock_in[lock_own]) begin
                state    <= UNLOCKED;
                lock_cnt <= 8'd0;
            end else if (lock_cnt == 8'(LOCK_MAX)) begin
                // forced release hands the next contention to the other master
                state                  <= UNLOCKED;
                lock_cnt               <= 8'd0;
                lock_err               <= 1'b1;
                last_gnt               <= lock_own;
                relock_block[lock_own] <= 1'b1;
            end else begin
                lock_cnt <= lock_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed and random checks of fixed and round-robin
// arbiter instances against a rule-level reference model.
module tb_periph_bus_arbiter;
    import periph_arb_pkg::*;
    localparam int LM = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req, rd, wr, lk;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] p_rdata;
    logic [1:0]  g0, g1, prd, pwr, lerr;
    logic [31:0] r0 [2];
    logic [31:0] r1 [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];

    int n_cmp = 0;
    int n_err = 0;

    // reference model state, index 0 = fixed priority, 1 = round-robin
    int m_last [2];
    int m_own [2];
    int m_cnt [2];
    bit m_lk [2];
    bit m_err [2];
    bit m_blk [2][2];

    periph_bus_arbiter #(.ARB_MODE(ARB_FIXED), .LOCK_MAX(LM)) u_fix (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_rd(rd[0]), .m0_wr(wr[0]), .m0_lock(lk[0]),
        .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_gnt(g0[0]), .m0_rdata(r0[0]),
        .m1_req(req[1]), .m1_rd(rd[1]), .m1_wr(wr[1]), .m1_lock(lk[1]),
        .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_gnt(g1[0]), .m1_rdata(r1[0]),
        .p_rd(prd[0]), .p_wr(pwr[0]), .p_addr(pa[0]), .p_wdata(pd[0]),
        .p_rdata(p_rdata), .lock_err(lerr[0])
    );

    periph_bus_arbiter #(.ARB_MODE(ARB_RR), .LOCK_MAX(LM)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_rd(rd[0]), .m0_wr(wr[0]), .m0_lock(lk[0]),
        .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_gnt(g0[1]), .m0_rdata(r0[1]),
        .m1_req(req[1]), .m1_rd(rd[1]), .m1_wr(wr[1]), .m1_lock(lk[1]),
        .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_gnt(g1[1]), .m1_rdata(r1[1]),
        .p_rd(prd[1]), .p_wr(pwr[1]), .p_addr(pa[1]), .p_wdata(pd[1]),
        .p_rdata(p_rdata), .lock_err(lerr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int d);
        if (m_lk[d]) return req[m_own[d]] ? m_own[d] : -1;
        if (req == 2'b11) return (d == 1) ? 1 - m_last[d] : 0;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d] = 1; m_own[d] = 0; m_cnt[d] = 0; m_lk[d] = 0; m_err[d] = 0;
            m_blk[d][0] = 0; m_blk[d][1] = 0;
        end
    endtask

    task automatic idle();
        req = '0; rd = '0; wr = '0; lk = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        p_rdata = '0;
    endtask

    task automatic set_m(input int m, input bit r, input bit rd_i, input bit wr_i,
                         input bit lk_i, input logic [31:0] a, input logic [31:0] wd);
        req[m] = r; rd[m] = rd_i; wr[m] = wr_i; lk[m] = lk_i; addr[m] = a; wdata[m] = wd;
    endtask

    task automatic settle();
        #2;
        for (int d = 0; d < 2; d++) begin
            int g, gi;
            g = pick(d);
            gi = (g < 0) ? 0 : g;
            chk($sformatf("m0_gnt[%0d]", d), 32'(g0[d]), 32'(g == 0));
            chk($sformatf("m1_gnt[%0d]", d), 32'(g1[d]), 32'(g == 1));
            chk($sformatf("p_wr[%0d]", d), 32'(pwr[d]), 32'(g >= 0 && wr[gi]));
            chk($sformatf("p_rd[%0d]", d), 32'(prd[d]), 32'(g >= 0 && rd[gi] && !wr[gi]));
            chk($sformatf("p_addr[%0d]", d), pa[d], (g >= 0) ? addr[gi] : 32'd0);
            chk($sformatf("p_wdata[%0d]", d), pd[d], (g >= 0) ? wdata[gi] : 32'd0);
            chk($sformatf("m0_rdata[%0d]", d), r0[d], (g == 0) ? p_rdata : 32'd0);
            chk($sformatf("m1_rdata[%0d]", d), r1[d], (g == 1) ? p_rdata : 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int g;
            g = pick(d);
            m_err[d] = 0;
            if (g >= 0) m_last[d] = g;
            if (m_lk[d]) begin
                if (!lk[m_own[d]]) m_lk[d] = 0;
                else if (m_cnt[d] == LM) begin
                    m_lk[d] = 0; m_err[d] = 1; m_blk[d][m_own[d]] = 1; m_last[d] = m_own[d];
                end else m_cnt[d]++;
            end else if (g >= 0 && lk[g] && !m_blk[d][g]) begin
                m_lk[d] = 1; m_own[d] = g; m_cnt[d] = 1;
            end
            for (int i = 0; i < 2; i++) if (!lk[i]) m_blk[d][i] = 0;
        end
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("lock_err[%0d]", d), 32'(lerr[d]), 32'(m_err[d]));
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_lock_err[%0d]", d), 32'(lerr[d]), 32'd0);
            chk($sformatf("rst_gnt[%0d]", d), 32'({g1[d], g0[d]}), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int pulses;
        logic [31:0] amap [6];
        amap[0] = ADDR_TH; amap[1] = ADDR_TL; amap[2] = ADDR_TCON;
        amap[3] = ADDR_LED; amap[4] = ADDR_SW; amap[5] = ADDR_DIGI;
        do_reset();

        // single master write
        set_m(0, 1, 0, 1, 0, ADDR_LED, 32'hA5);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("single_m0_gnt", 32'(g0[d]), 32'd1);
            chk("single_p_wr", 32'(pwr[d]), 32'd1);
            chk("single_p_addr", pa[d], 32'h4000_000C);
            chk("single_p_wdata", pd[d], 32'hA5);
            chk("single_m1_gnt", 32'(g1[d]), 32'd0);
            chk("single_m1_rdata", r1[d], 32'd0);
        end
        cycle();

        // contention: round-robin alternates, fixed always m0
        do_reset();
        set_m(0, 1, 1, 0, 0, ADDR_SW, 0);
        set_m(1, 1, 1, 0, 0, ADDR_SW, 0);
        p_rdata = 32'h3C;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rr_m0_gnt", 32'(g0[1]), 32'(k % 2 == 0));
            chk("rr_m1_gnt", 32'(g1[1]), 32'(k % 2 == 1));
            chk("rr_m0_rdata", r0[1], (k % 2 == 0) ? 32'h3C : 32'd0);
            chk("rr_m1_rdata", r1[1], (k % 2 == 1) ? 32'h3C : 32'd0);
            chk("fix_m0_gnt", 32'(g0[0]), 32'd1);
            chk("fix_m1_gnt", 32'(g1[0]), 32'd0);
            cycle();
        end

        // locked read-modify-write by m1
        do_reset();
        set_m(0, 1, 1, 0, 0, ADDR_TH, 0);
        cycle();
        set_m(1, 1, 1, 0, 1, ADDR_TCON, 0);
        #2;
        chk("rmw_rd_m1_gnt", 32'(g1[1]), 32'd1);
        cycle();
        set_m(1, 1, 0, 1, 0, ADDR_TCON, 32'h3);
        #2;
        chk("rmw_wr_m1_gnt", 32'(g1[1]), 32'd1);
        chk("rmw_wr_m0_gnt", 32'(g0[1]), 32'd0);
        cycle();
        set_m(1, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rmw_after_m0_gnt", 32'(g0[1]), 32'd1);
        cycle();

        // lock timeout and relock blocking
        do_reset();
        set_m(0, 1, 0, 1, 1, ADDR_TCON, 32'h1);
        set_m(1, 1, 1, 0, 0, ADDR_SW, 0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            #2;
            if (k == 5) chk("to_m1_gnt_after", 32'(g1[1]), 32'd1);
            if (k == 7) chk("to_no_relock_m1_gnt", 32'(g1[1]), 32'd1);
            cycle();
            pulses += int'(lerr[1]);
        end
        chk("to_err_pulses", 32'(pulses), 32'd1);
        lk[0] = 1'b0;
        cycle();
        lk[0] = 1'b1;
        cycle();
        cycle();

        // asynchronous reset while m1 holds the lock
        do_reset();
        set_m(1, 1, 1, 0, 1, ADDR_TCON, 0);
        cycle();
        set_m(0, 1, 1, 0, 0, ADDR_LED, 0);
        #2;
        chk("ar_locked_m0_gnt", 32'(g0[1]), 32'd0);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("ar_lock_err", 32'(lerr[d]), 32'd0);
            chk("ar_m0_gnt", 32'(g0[d]), 32'd1);
            chk("ar_m1_gnt", 32'(g1[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        lk = '0;
        #2;
        chk("ar_first_m0_gnt", 32'(g0[1]), 32'd1);
        cycle();

        // random traffic with sticky lock requests
        for (int k = 0; k < 800; k++) begin
            for (int m = 0; m < 2; m++) begin
                req[m] = ($urandom_range(0, 3) != 0);
                rd[m] = $urandom_range(0, 1) == 1;
                wr[m] = $urandom_range(0, 2) == 0;
                if ($urandom_range(0, 5) == 0) lk[m] = ~lk[m];
                addr[m] = amap[$urandom_range(0, 5)];
                wdata[m] = $urandom;
            end
            p_rdata = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
